// File: rtl/mux_pkg.sv
// Shared definitions for the mux-scan serializer: state encoding and default geometry.
package mux_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SEL_W = 4;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT
   } state_e;

endpackage : mux_pkg

// File: rtl/mux16_sel_tree.sv
// Combinational 16:1 select built as four 4:1 muxes feeding a final 4:1 stage.
module mux16_sel_tree (
   input  logic [15:0] in,
   input  logic [3:0]  sel,
   output logic        out
);

   logic [3:0] stage1;

   always_comb begin
      for (int g = 0; g < 4; g++) begin
         stage1[g] = 1'b0;
         unique case (sel[1:0])
            2'd0: stage1[g] = in[4*g + 0];
            2'd1: stage1[g] = in[4*g + 1];
            2'd2: stage1[g] = in[4*g + 2];
            2'd3: stage1[g] = in[4*g + 3];
            default: stage1[g] = 1'b0;
         endcase
      end
   end

   always_comb begin
      out = 1'b0;
      unique case (sel[3:2])
         2'd0: out = stage1[0];
         2'd1: out = stage1[1];
         2'd2: out = stage1[2];
         2'd3: out = stage1[3];
         default: out = 1'b0;
      endcase
   end

endmodule : mux16_sel_tree

// File: rtl/mux_scan_serializer.sv
// Holds a word and walks a select counter across the mux tree, one serial beat per handshake.
//
//   state   | meaning
//   S_IDLE  | no word held, in_ready high, no beats offered
//   S_SHIFT | word held, ser_out = word_q[sel_q] offered each cycle
module mux_scan_serializer
   import mux_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int SEL_W     = DEF_SEL_W,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ser_out,
   output logic [SEL_W-1:0] sel_out,
   output logic             last,
   output logic             busy
);

   localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(WIDTH-1) : '0;
   localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? '0 : SEL_W'(WIDTH-1);

   state_e           state_q;
   logic [WIDTH-1:0] word_q;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] sel_d;
   logic             last_q;
   logic             load;
   logic             beat_acc;

   // Ready on the final accepted beat too, so consecutive words stream without a bubble.
   assign in_ready = !rst && ((state_q == S_IDLE) || (last_q && out_ready));
   assign load     = in_valid && in_ready;
   assign beat_acc = (state_q == S_SHIFT) && out_ready;

   always_comb begin
      sel_d = sel_q;
      if (MSB_FIRST) sel_d = sel_q - SEL_W'(1);
      else           sel_d = sel_q + SEL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         sel_q   <= SEL_START;
         last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (load) begin
                  state_q <= S_SHIFT;
                  word_q  <= in_data;
                  sel_q   <= SEL_START;
                  last_q  <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (beat_acc) begin
                  if (last_q) begin
                     sel_q  <= SEL_START;
                     last_q <= 1'b0;
                     if (load) word_q  <= in_data;
                     else      state_q <= S_IDLE;
                  end else begin
                     sel_q  <= sel_d;
                     last_q <= (sel_d == SEL_END);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid = (state_q == S_SHIFT);
   assign busy      = (state_q == S_SHIFT);
   assign last      = last_q;
   assign sel_out   = sel_q;

   mux16_sel_tree u_tree (
      .in  (word_q),
      .sel (sel_q),
      .out (ser_out)
   );

endmodule : mux_scan_serializer

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: LSB-first and MSB-first serializer instances driven from one sequence.
module tb_mux_scan_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_ser, l_last, l_busy;
   logic [15:0] l_in_data;
   logic [3:0]  l_sel;

   logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_ser, m_last, m_busy;
   logic [15:0] m_in_data;
   logic [3:0]  m_sel;

   int vectors     = 0;
   int miscompares = 0;

   bit exp_3f0d [16] = '{1,0,1,1,0,0,0,0,1,1,1,1,1,1,0,0};

   mux_scan_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst),
      .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
      .out_valid(l_out_valid), .out_ready(l_out_ready),
      .ser_out(l_ser), .sel_out(l_sel), .last(l_last), .busy(l_busy)
   );

   mux_scan_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst),
      .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
      .out_valid(m_out_valid), .out_ready(m_out_ready),
      .ser_out(m_ser), .sel_out(m_sel), .last(m_last), .busy(m_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_l(input string tag, input int sel, input bit ser, input bit lst);
      chk({tag, " l_out_valid"}, 32'(l_out_valid), 32'd1);
      chk({tag, " l_sel"},       32'(l_sel),       32'(sel));
      chk({tag, " l_ser"},       32'(l_ser),       32'(ser));
      chk({tag, " l_last"},      32'(l_last),      32'(lst));
   endtask

   initial begin
      // 1: reset with in_valid asserted
      rst = 1'b1;
      l_in_valid = 1'b1; l_in_data = 16'hffff; l_out_ready = 1'b0;
      m_in_valid = 1'b0; m_in_data = 16'h0000; m_out_ready = 1'b1;
      @(negedge clk);
      chk("rst in_ready",  32'(l_in_ready),  32'd0);
      chk("rst out_valid", 32'(l_out_valid), 32'd0);
      chk("rst last",      32'(l_last),      32'd0);
      chk("rst busy",      32'(l_busy),      32'd0);
      @(negedge clk);
      chk("rst ser",       32'(l_ser),       32'd0);
      chk("rst sel",       32'(l_sel),       32'd0);
      chk("rst msb sel",   32'(m_sel),       32'hf);
      chk("rst in_ready2", 32'(l_in_ready),  32'd0);
      rst = 1'b0; l_in_valid = 1'b0;
      @(negedge clk);
      chk("post-rst in_ready",  32'(l_in_ready),  32'd1);
      chk("post-rst out_valid", 32'(l_out_valid), 32'd0);

      // 2: 16'h3f0d LSB-first, free-running
      l_in_data = 16'h3f0d; l_in_valid = 1'b1; l_out_ready = 1'b1;
      @(negedge clk);
      l_in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk_l($sformatf("t2 beat%0d", k), k, exp_3f0d[k], k == 15);
         @(negedge clk);
      end
      chk("t2 idle out_valid", 32'(l_out_valid), 32'd0);
      chk("t2 idle busy",      32'(l_busy),      32'd0);
      chk("t2 idle sel",       32'(l_sel),       32'd0);
      chk("t2 idle in_ready",  32'(l_in_ready),  32'd1);

      // 3: stall at sel=b for 3 cycles
      l_in_valid = 1'b1;
      @(negedge clk);
      l_in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk_l($sformatf("t3 beat%0d", k), k, exp_3f0d[k], k == 15);
         if (k == 11) begin
            l_out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk_l($sformatf("t3 stall%0d", s), 11, 1'b1, 1'b0);
               chk("t3 stall in_ready", 32'(l_in_ready), 32'd0);
            end
            l_out_ready = 1'b1;
         end
         @(negedge clk);
      end
      chk("t3 idle out_valid", 32'(l_out_valid), 32'd0);

      // 4: back-to-back 16'h3f0d then 16'h8001
      l_in_valid = 1'b1;
      @(negedge clk);
      l_in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k >= 10) begin
            l_in_valid = 1'b1;
            l_in_data  = 16'h8001;
         end
         chk_l($sformatf("t4a beat%0d", k), k, exp_3f0d[k], k == 15);
         chk($sformatf("t4a in_ready%0d", k), 32'(l_in_ready), 32'(k == 15));
         @(negedge clk);
      end
      l_in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk_l($sformatf("t4b beat%0d", k), k, (k == 0) || (k == 15), k == 15);
         @(negedge clk);
      end
      chk("t4 idle out_valid", 32'(l_out_valid), 32'd0);

      // 5: MSB-first instance, 16'h8001
      m_in_data = 16'h8001; m_in_valid = 1'b1;
      @(negedge clk);
      m_in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("t5 m_out_valid%0d", k), 32'(m_out_valid), 32'd1);
         chk($sformatf("t5 m_sel%0d", k),       32'(m_sel),       32'(15 - k));
         chk($sformatf("t5 m_ser%0d", k),       32'(m_ser),       32'((k == 0) || (k == 15)));
         chk($sformatf("t5 m_last%0d", k),      32'(m_last),      32'(k == 15));
         @(negedge clk);
      end
      chk("t5 idle m_out_valid", 32'(m_out_valid), 32'd0);
      chk("t5 idle m_sel",       32'(m_sel),       32'hf);

      // 6: reset mid-word at sel=7
      l_in_data = 16'hffff; l_in_valid = 1'b1;
      @(negedge clk);
      l_in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk_l($sformatf("t6 beat%0d", k), k, 1'b1, 1'b0);
         if (k < 7) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("t6 out_valid", 32'(l_out_valid), 32'd0);
      chk("t6 busy",      32'(l_busy),      32'd0);
      chk("t6 sel",       32'(l_sel),       32'd0);
      chk("t6 ser",       32'(l_ser),       32'd0);
      chk("t6 last",      32'(l_last),      32'd0);
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk($sformatf("t6 quiet%0d", s), 32'(l_out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mux_scan_serializer
